// File: rtl/fetch_ifu_ctrl.sv
// Instruction-fetch initiator: owns the fetch PC, issues sequential requests, pairs responses
// with their PCs, buffers them for decode and recovers from redirects by dropping stale data.
module fetch_ifu_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  DEPTH       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   if_req_valid_o,
  input  logic                   if_req_ready_i,
  output logic [PC_WIDTH-1:0]    if_req_pc_o,
  input  logic                   if_resp_valid_i,
  output logic                   if_resp_ready_o,
  input  logic                   if_resp_misalign_i,
  input  logic                   if_resp_bus_err_i,
  input  logic [INSTR_WIDTH-1:0] if_resp_instr_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PC_WIDTH-1:0]    out_pc_o,
  output logic [INSTR_WIDTH-1:0] out_instr_o,
  output logic                   out_misalign_o,
  output logic                   out_bus_err_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [0:0]    ST_RUN   = 1'b0;
  localparam logic [0:0]    ST_HALT  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [AW:0]         inflight_q, inflight_d;
  logic [AW:0]         drop_q, drop_d;
  logic [AW:0]         pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [AW:0]         buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

  logic [PC_WIDTH-1:0]    pcq_mem_q   [DEPTH];
  logic [PC_WIDTH-1:0]    buf_pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] buf_instr_q [DEPTH];
  logic                   buf_mis_q   [DEPTH];
  logic                   buf_err_q   [DEPTH];

  logic                req_fire, resp_fire, out_fire;
  logic                resp_keep, push_buf, pop_buf, pcq_push, pcq_pop;
  logic                pcq_empty, buf_empty, buf_full, credit_ok, drop_zero;
  logic [AW:0]         buf_count;
  logic [PC_WIDTH-1:0] resp_pc;

  assign buf_count = buf_wr_q - buf_rd_q;
  assign buf_empty = (buf_count == '0);
  assign buf_full  = (buf_count == DEPTH_C);
  assign pcq_empty = (pcq_wr_q == pcq_rd_q);
  assign drop_zero = (drop_q == '0);
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, buf_count}) < {1'b0, DEPTH_C};

  assign if_req_valid_o  = !rst_i && (state_q == ST_RUN) && credit_ok;
  assign if_req_pc_o     = pc_q;
  assign req_fire        = if_req_valid_o && if_req_ready_i;
  // A response is only taken when something is outstanding, including a request firing now.
  assign if_resp_ready_o = !rst_i && ((inflight_q != '0) || req_fire) && (!drop_zero || !buf_full);
  assign resp_fire       = if_resp_valid_i && if_resp_ready_o;
  assign out_valid_o     = !buf_empty;
  assign out_fire        = out_valid_o && out_ready_i;

  assign resp_keep = resp_fire && drop_zero;
  assign resp_pc   = pcq_empty ? pc_q : pcq_mem_q[pcq_rd_q[AW-1:0]];
  assign push_buf  = resp_keep && !redirect_valid_i;
  assign pop_buf   = out_fire && !redirect_valid_i;
  // A zero-latency response consumes its own request's PC directly, bypassing the queue.
  assign pcq_push  = req_fire && !(resp_keep && pcq_empty);
  assign pcq_pop   = resp_keep && !pcq_empty;

  assign out_pc_o       = out_valid_o ? buf_pc_q[buf_rd_q[AW-1:0]]    : '0;
  assign out_instr_o    = out_valid_o ? buf_instr_q[buf_rd_q[AW-1:0]] : '0;
  assign out_misalign_o = out_valid_o && buf_mis_q[buf_rd_q[AW-1:0]];
  assign out_bus_err_o  = out_valid_o && buf_err_q[buf_rd_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    pc_d       = req_fire ? pc_q + PC_WIDTH'(4) : pc_q;
    inflight_d = inflight_q + {{AW{1'b0}}, req_fire} - {{AW{1'b0}}, resp_fire};
    drop_d     = (resp_fire && !drop_zero) ? drop_q - ONE_C : drop_q;
    pcq_wr_d   = pcq_push ? pcq_wr_q + ONE_C : pcq_wr_q;
    pcq_rd_d   = pcq_pop  ? pcq_rd_q + ONE_C : pcq_rd_q;
    buf_wr_d   = push_buf ? buf_wr_q + ONE_C : buf_wr_q;
    buf_rd_d   = pop_buf  ? buf_rd_q + ONE_C : buf_rd_q;
    if (push_buf && (if_resp_misalign_i || if_resp_bus_err_i)) state_d = ST_HALT;
    // Everything still outstanding after this cycle's fires belongs to the old stream.
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i;
      state_d  = ST_RUN;
      drop_d   = inflight_d;
      pcq_wr_d = '0;
      pcq_rd_d = '0;
      buf_wr_d = '0;
      buf_rd_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pcq_push) pcq_mem_q[pcq_wr_q[AW-1:0]] <= pc_q;
    if (push_buf) begin
      buf_pc_q[buf_wr_q[AW-1:0]]    <= resp_pc;
      buf_instr_q[buf_wr_q[AW-1:0]] <= if_resp_instr_i;
      buf_mis_q[buf_wr_q[AW-1:0]]   <= if_resp_misalign_i;
      buf_err_q[buf_wr_q[AW-1:0]]   <= if_resp_bus_err_i;
    end
  end

endmodule
